ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Drives the shared open-drain ps2_clk/ps2_data pins and samples the device ACK.
//  Runs in parallel with the existing PS/2 receiver in the top. busy gates that receiver while the host owns the bus.
// PARAMETERS
//  INHIBIT_CYCLES  5000     clk cycles ps2_clk is held low before the request (100us @50MHz)
//  TIMEOUT_CYCLES  750000   max clk cycles from request to ACK release (15ms @50MHz)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  reset: synchronous, active-high
//  tx_valid     in   1  request to send tx_data
//  tx_data      in   8  command byte
//  tx_ready     out  1  1 only in IDLE; transfer accepted when tx_valid&tx_ready
//  ps2_clk_i    in   1  raw PS/2 clock pin level (asynchronous)
//  ps2_data_i   in   1  raw PS/2 data pin level (asynchronous)
//  ps2_clk_oe   out  1  1 = pull ps2_clk low, 0 = release (pad is open-drain)
//  ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release
//  busy         out  1  ~tx_ready
//  done         out  1  one-cycle pulse at the end of every accepted transfer (ok, nack or timeout)
//  ack_ok       out  1  device ACKed the last transfer; held until next accept
//  err_nack     out  1  device did not pull data low on clock 11; held until next accept
//  err_timeout  out  1  TIMEOUT_CYCLES expired; held until next accept
// BEHAVIOUR
//  Reset: state IDLE; tx_ready=1; ps2_clk_oe=ps2_data_oe=0; busy=done=ack_ok=err_nack=err_timeout=0.
//   Applies on the next edge regardless of state, so both lines are released immediately mid-transfer.
//  Sync: ps2_clk_i and ps2_data_i each pass through 2 FFs. fall = prev_sync_clk & ~sync_clk (3rd FF).
//  FSM (one-hot or binary, registered outputs):
//   IDLE    on accept: latch tx_data and par = ~^tx_data (odd parity); clear status flags;
//           inhibit counter=0 -> INHIBIT.
//   INHIBIT clk_oe=1, data_oe=0, for exactly INHIBIT_CYCLES cycles. Then data_oe=1 (start bit 0),
//           clk_oe=0, timeout counter=0 -> REQ.
//   REQ     hold start bit. On fall: present bit0 (data_oe = ~bit), idx=0 -> SEND.
//   SEND    on fall: idx++, present frame[idx]. frame = {stop=1, par, data[7:0]}, LSB first.
//           Presenting stop (idx 9) releases data_oe -> ACK_WAIT.
//   ACK_WAIT on fall (11th): sample sync data. 0 -> ack_ok=1; 1 -> err_nack=1. -> RELEASE.
//   RELEASE wait until sync clk==1 && sync data==1, then done=1 for one cycle -> IDLE.
//  Timeout: counter runs in REQ/SEND/ACK_WAIT/RELEASE. On reaching TIMEOUT_CYCLES-1:
//   release both oe, err_timeout=1, done=1 -> IDLE. Timeout takes priority over a simultaneous fall.
//  tx_valid while busy is ignored (not queued). Data changes only on falling edges.
//   The host never drives ps2_clk after INHIBIT.
//  Counter widths: $clog2(param+1). Frame index 4 bits, saturating at 9.
// STRUCTURE
//  Shared header ps2_defs.vh: state encodings; command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF,
//   CMD_RESEND=8'hFE; response RSP_ACK=8'hFA.
//  Sub-module ps2_sync_edge: 2-FF synchronizer + falling-edge detect, reusable by the receiver.
//  Top instantiates pad logic: ps2_clk = ps2_clk_oe ? 1'b0 : 1'bz (same for data).
// TESTING (bench: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000, device model clocking at 10 kHz-equivalent)
//  1 Send 0xED -> clk low exactly 8 cycles. Model samples start 0, data LSB-first 1,0,1,1,0,1,1,1, par 1, stop 1.
//    Model ACKs -> done pulse, ack_ok=1, both oe 0, tx_ready=1.
//  2 Send 0x00 and 0xFF -> parity bit 1 for both; send 0x01 -> parity 0.
//  3 Model holds data high on clock 11 -> err_nack=1, ack_ok=0, one done pulse.
//  4 Model never clocks -> err_timeout=1 exactly 2000 cycles after REQ entry; both oe 0; tx_ready=1.
//  5 tx_valid with 0x55 pulsed during SEND of 0xED -> ignored; model receives only 0xED.
//  6 rst asserted mid-SEND -> next cycle ps2_clk_oe=ps2_data_oe=0, tx_ready=1, all flags 0;
//    a fresh 0xFF transfer then completes with ack_ok=1.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// rtl/ps2_host_tx_pkg.sv - shared PS/2 host transmitter types and constants
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK_WAIT,
    ST_RELEASE
  } state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // Frame index of the last data-phase bit; the next fall presents the stop bit
  localparam logic [3:0] IDX_PAR  = 4'd8;
  localparam logic [3:0] IDX_STOP = 4'd9;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync_edge.sv
// rtl/ps2_host_tx_sync_edge.sv - 2-FF synchronizer with falling-edge detect
module ps2_host_tx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);

  logic meta, sync, prev;

  // Reset to 1 so an idle (pulled-up) bus never produces a spurious fall
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_nack,
  output logic       err_timeout
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nx;
  logic [7:0]      data_q;
  logic            par_q;
  logic [3:0]      idx;
  logic [IW-1:0]   icnt;
  logic [TW-1:0]   tcnt;
  logic            clk_s, clk_fall, data_s, data_fall_unused;
  logic            active, timeout;
  logic [9:0]      frame;

  ps2_host_tx_sync_edge u_sync_clk (
    .clk(clk), .rst(rst), .din(ps2_clk_i), .level(clk_s), .fall(clk_fall)
  );

  ps2_host_tx_sync_edge u_sync_data (
    .clk(clk), .rst(rst), .din(ps2_data_i), .level(data_s), .fall(data_fall_unused)
  );

  assign frame   = {1'b1, par_q, data_q};
  assign active  = (state == ST_REQ) || (state == ST_SEND) ||
                   (state == ST_ACK_WAIT) || (state == ST_RELEASE);
  assign timeout = active && (tcnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (tx_valid)                    state_nx = ST_INHIBIT;
        ST_INHIBIT:  if (icnt == INH_LAST)            state_nx = ST_REQ;
        ST_REQ:      if (clk_fall)                    state_nx = ST_SEND;
        ST_SEND:     if (clk_fall && idx == IDX_PAR)  state_nx = ST_ACK_WAIT;
        ST_ACK_WAIT: if (clk_fall)                    state_nx = ST_RELEASE;
        ST_RELEASE:  if (clk_s && data_s)             state_nx = ST_IDLE;
        default:                                      state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_ready    = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state)
      ST_IDLE:    tx_ready    = 1'b1;
      ST_INHIBIT: ps2_clk_oe  = 1'b1;
      ST_REQ:     ps2_data_oe = 1'b1;
      ST_SEND:    ps2_data_oe = ~frame[idx];
      default:    ;
    endcase
  end

  assign busy = ~tx_ready;

  // Datapath and sticky status; done is a registered one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      par_q       <= 1'b0;
      idx         <= '0;
      icnt        <= '0;
      tcnt        <= '0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err_nack    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            data_q      <= tx_data;
            par_q       <= odd_parity(tx_data);
            icnt        <= '0;
            ack_ok      <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
          end
        end
        ST_INHIBIT: begin
          icnt <= icnt + 1'b1;
          tcnt <= '0;
        end
        default: begin
          tcnt <= tcnt + 1'b1;
          if (timeout) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
          end else begin
            case (state)
              ST_REQ:      if (clk_fall) idx <= '0;
              ST_SEND:     if (clk_fall && idx != IDX_STOP) idx <= idx + 1'b1;
              ST_ACK_WAIT: if (clk_fall) begin
                ack_ok   <= ~data_s;
                err_nack <= data_s;
              end
              ST_RELEASE:  if (clk_s && data_s) done <= 1'b1;
              default:     ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench with open-drain PS/2 device model
module tb_ps2_host_tx;

  localparam int INH  = 8;
  localparam int TO   = 2000;
  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err_nack, err_timeout;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       bus_clk, bus_data;

  assign bus_clk  = ~ps2_clk_oe  & dev_clk;
  assign bus_data = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ps2_clk_i(bus_clk), .ps2_data_i(bus_data), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .ack_ok(ack_ok),
    .err_nack(err_nack), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0, acc_cyc = -1000, done_cyc = 0, done_cnt = 0;
  bit mon_en = 1'b0;
  bit dev_abort = 1'b0, dev_finished = 1'b0, dev_seen = 1'b0;
  logic [10:0] dev_frame;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Expected wire frame, LSB first: start, data[0..7], odd parity, stop
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  // Clock is only pulled low during the INH cycles that follow an accept
  initial begin
    logic exp_clk;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) begin
        exp_clk = (cyc >= acc_cyc) && (cyc < acc_cyc + INH);
        check("clk_oe_window", {31'b0, ps2_clk_oe}, {31'b0, exp_clk});
        if (exp_clk) check("data_oe_in_inhibit", {31'b0, ps2_data_oe}, 32'd0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic dwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dev_run(input bit ack);
    int n = 0;
    dev_frame = '0;
    dev_seen  = 1'b0;
    while (!(bus_clk && !bus_data) && n < 200 && !dev_abort) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200 || dev_abort) begin
      dev_finished = 1'b1;
      return;
    end
    dev_seen     = 1'b1;
    dev_frame[0] = bus_data;
    dwait(5);
    for (int i = 1; i <= 10; i++) begin
      if (dev_abort) break;
      dev_clk = 1'b0;
      dwait(HALF);
      dev_frame[i] = bus_data;
      dev_clk = 1'b1;
      dwait(HALF);
    end
    if (!dev_abort) begin
      if (ack) dev_data = 1'b0;
      dwait(5);
      dev_clk = 1'b0;
      dwait(HALF);
      dev_clk = 1'b1;
      dwait(5);
    end
    dev_clk      = 1'b1;
    dev_data     = 1'b1;
    dev_finished = 1'b1;
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    acc_cyc  = cyc + 1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && done_cnt == 0; i++) @(negedge clk);
    check("done_seen", {31'b0, done_cnt != 0}, 32'd1);
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input int glitch_at);
    done_cnt = 0;
    dev_finished = 1'b0;
    fork
      dev_run(ack);
    join_none
    start_tx(d);
    if (glitch_at > 0) begin
      dwait(glitch_at);
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    wait_done(1500);
    dwait(10);
    check("dev_req_seen", {31'b0, dev_seen}, 32'd1);
    check("dev_finished", {31'b0, dev_finished}, 32'd1);
    check("frame", {21'b0, dev_frame}, {21'b0, model_frame(d)});
    check("ack_ok", {31'b0, ack_ok}, {31'b0, ack});
    check("err_nack", {31'b0, err_nack}, {31'b0, ~ack});
    check("err_timeout", {31'b0, err_timeout}, 32'd0);
    check("idle_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("idle_ready", {30'b0, tx_ready, busy}, 32'd2);
    check("done_count", done_cnt, 32'd1);
  endtask

  initial begin
    dwait(3);
    check("rst_ready_busy", {30'b0, tx_ready, busy}, 32'd2);
    check("rst_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_flags", {28'b0, done, ack_ok, err_nack, err_timeout}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    dwait(3);

    run_xfer(8'hED, 1'b1, 0);
    check("frame_ed_literal", {21'b0, dev_frame}, {21'b0, 11'b11111011010});

    run_xfer(8'h00, 1'b1, 0);
    check("parity_00", {31'b0, dev_frame[9]}, 32'd1);
    run_xfer(8'hFF, 1'b1, 0);
    check("parity_ff", {31'b0, dev_frame[9]}, 32'd1);
    run_xfer(8'h01, 1'b1, 0);
    check("parity_01", {31'b0, dev_frame[9]}, 32'd0);

    run_xfer(8'hAB, 1'b0, 0);

    done_cnt = 0;
    start_tx(8'h3C);
    wait_done(TO + 100);
    check("timeout_latency", done_cyc - acc_cyc, INH + TO);
    check("timeout_flag", {29'b0, err_timeout, ack_ok, err_nack}, 32'd4);
    dwait(3);
    check("timeout_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("timeout_ready", {31'b0, tx_ready}, 32'd1);
    check("timeout_done_count", done_cnt, 32'd1);

    run_xfer(8'hED, 1'b1, 60);
    check("glitch_frame_ed", {21'b0, dev_frame}, {21'b0, 11'b11111011010});
    dwait(30);
    check("glitch_no_second", done_cnt, 32'd1);

    done_cnt = 0;
    dev_finished = 1'b0;
    fork
      dev_run(1'b1);
    join_none
    start_tx(8'hED);
    dwait(100);
    dev_abort = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("midrst_ready", {30'b0, tx_ready, busy}, 32'd2);
    check("midrst_flags", {28'b0, done, ack_ok, err_nack, err_timeout}, 32'd0);
    for (int i = 0; i < 100 && !dev_finished; i++) @(negedge clk);
    check("midrst_dev_stop", {31'b0, dev_finished}, 32'd1);
    dev_abort = 1'b0;
    dwait(5);
    run_xfer(8'hFF, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
